mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Multicycle signed multiply/divide unit for the MIPS datapath. Consumes registers A and B,
//   produces the 64-bit result that the HiReg/LoReg pair latches (mult: {hi,lo}=A*B;
//   div: lo=A/B, hi=A%B). Driven by ctrl_unit with a start/done handshake; ctrl_unit
//   holds its wait state until done and asserts HiWrite/LoWrite in the done cycle.
// PARAMETERS
//   WIDTH  32  operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//   clk         in   1        system clock, rising edge
//   reset       in   1        synchronous, active-high
//   mult_start  in   1        request signed multiply; sampled only in IDLE
//   div_start   in   1        request signed divide; sampled only in IDLE
//   a_in        in   WIDTH    operand A (multiplicand / dividend), signed
//   b_in        in   WIDTH    operand B (multiplier / divisor), signed
//   hi_out      out  WIDTH    mult: product[63:32]; div: remainder
//   lo_out      out  WIDTH    mult: product[31:0];  div: quotient
//   busy        out  1        high in MULT, DIV and FIN
//   done        out  1        one-cycle pulse: hi_out/lo_out valid this cycle
//   div_zero    out  1        one-cycle pulse with done: divide by zero, hi/lo unchanged
// BEHAVIOUR
//   Reset: state=IDLE, hi_out=lo_out=0, busy=done=div_zero=0, counter=0. Reset mid-operation
//     aborts immediately; no done pulse follows.
//   States: IDLE, MULT, DIV, FIN.
//   IDLE: mult_start -> latch operands, cnt=0, go MULT. Else div_start with b_in!=0 ->
//     latch |a|,|b| and both sign bits, cnt=0, go DIV. div_start with b_in==0 -> go FIN
//     with div_zero flag set, no iterations. Both starts high: multiply wins, div ignored.
//   Starts while busy are ignored (not queued).
//   MULT: radix-2 Booth, one step per cycle, 32 steps. Accumulator is WIDTH+1 bits so a
//     -2^31 multiplicand subtracts without overflow. Each step: examine {Q0,Q-1}; 01 add M,
//     10 subtract M; then arithmetic shift right of {Acc,Q,Q-1}. After step 31 -> FIN.
//   DIV: restoring division on magnitudes, one quotient bit per cycle, 32 cycles, -> FIN.
//     Quotient negated if signs differ (truncation toward zero); remainder takes dividend sign.
//     0x80000000 / -1 -> lo=0x80000000, hi=0 (wraps, no flag).
//   Result regs hi_out/lo_out load on the edge entering FIN (not on div_zero path).
//   FIN: done=1 (and div_zero=1 if flagged) for exactly this cycle; next edge -> IDLE.
//   Latency: start cycle = C; MULT/DIV occupy C+1..C+32; done in C+33. Div-by-zero:
//     done+div_zero in C+1. New start accepted in the cycle after FIN.
//   hi_out/lo_out hold their value until the next completed operation.
// STRUCTURE
//   Shared package mult_div_pkg: state encoding (IDLE/MULT/DIV/FIN localparams), ITER=WIDTH,
//     counter width = $clog2(WIDTH).
//   One combinational sub-module: div_iter_step (partial-remainder shift, trial subtract,
//     quotient bit, restore select). Booth step, FSM and sign fix-up stay in this module.
// TESTING
//   mult 7 x -3 -> done in cycle C+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high C+1..C+33.
//   mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000 (33-bit accumulator check).
//   div -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div 0x80000000/-1 -> lo=0x80000000, hi=0.
//   div 5 / 0 -> done and div_zero high in C+1 only, hi/lo keep previous values, no DIV state.
//   mult_start and div_start together, then start pulses during MULT -> only the multiply
//     runs, one done pulse; reset at C+10 -> outputs 0, IDLE next cycle, no done.
//   Back-to-back: start again in cycle after FIN -> accepted, second result correct.

Source files
------------

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared widths and FSM encoding for the multiply/divide unit
package mult_div_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = DATA_W;
  localparam int CNT_W  = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// rtl/mult_div_unit_div_step.sv - one restoring-division step on unsigned magnitudes
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Partial remainder stays below 2*divisor, so the extra top bit of trial is its sign.
  assign shifted = {rem_in, next_bit};
  assign trial   = shifted - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed Booth multiply / restoring divide unit
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH:0]   acc, m_reg, booth_sum, acc_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic             q_m1;

  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, rem_fix, quo_fix;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             qbit, sign_a, sign_b;

  logic             dz_flag;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  // Booth step: accumulator is one bit wider so subtracting -2^(WIDTH-1) cannot overflow.
  always_comb begin
    booth_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   booth_sum = acc + m_reg;
      2'b10:   booth_sum = acc - m_reg;
      default: booth_sum = acc;
    endcase
  end

  assign acc_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign q_nxt   = {booth_sum[0], q_reg[WIDTH-1:1]};

  assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

  div_iter_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in   (rem),
    .next_bit (quo[WIDTH-1]),
    .divisor  (dvsr),
    .rem_out  (rem_nxt),
    .q_bit    (qbit)
  );

  assign quo_nxt = {quo[WIDTH-2:0], qbit};
  assign quo_fix = (sign_a ^ sign_b) ? -quo_nxt : quo_nxt;
  assign rem_fix = sign_a ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (mult_start)     state_nxt = MULT;
        else if (div_start) state_nxt = (b_in == '0) ? FIN : DIV;
      end
      MULT: begin
        busy = 1'b1;
        if (last) state_nxt = FIN;
      end
      DIV: begin
        busy = 1'b1;
        if (last) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        div_zero  = dz_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dz_flag <= 1'b0;
      cnt     <= '0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_start) begin
            acc     <= '0;
            m_reg   <= {a_in[WIDTH-1], a_in};
            q_reg   <= b_in;
            q_m1    <= 1'b0;
            cnt     <= '0;
            dz_flag <= 1'b0;
          end else if (div_start) begin
            if (b_in == '0) begin
              dz_flag <= 1'b1;
            end else begin
              rem     <= '0;
              quo     <= a_mag;
              dvsr    <= b_mag;
              sign_a  <= a_in[WIDTH-1];
              sign_b  <= b_in[WIDTH-1];
              cnt     <= '0;
              dz_flag <= 1'b0;
            end
          end
        end
        MULT: begin
          acc   <= acc_nxt;
          q_reg <= q_nxt;
          q_m1  <= q_reg[0];
          cnt   <= cnt + CW'(1);
          if (last) begin
            hi_out <= acc_nxt[WIDTH-1:0];
            lo_out <= q_nxt;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            hi_out <= rem_fix;
            lo_out <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start, div_start;
  logic [31:0] a_in, b_in;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int errors = 0;
  int checks = 0;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a_in       (a_in),
    .b_in       (b_in),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start in the current cycle C; return with the sample point in the done cycle (n = offset from C).
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        output int n, output int busy_n);
    mult_start = m;
    div_start  = d;
    a_in       = a;
    b_in       = b;
    tick();
    mult_start = 1'b0;
    div_start  = 1'b0;
    n      = 1;
    busy_n = int'(busy);
    while (!done && n < 100) begin
      tick();
      n++;
      busy_n += int'(busy);
    end
  endtask

  initial begin
    int n, bn, dones;
    logic [31:0] cap_hi, cap_lo;

    reset = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a_in = '0;
    b_in = '0;
    tick();
    tick();
    check("reset_hi", {32'd0, hi_out}, 64'd0);
    check("reset_lo", {32'd0, lo_out}, 64'd0);
    check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", {63'd0, busy}, 64'd0);

    // 7 x -3 = -21
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, n, bn);
    check("mul1_latency", 64'(n), 64'd33);
    check("mul1_busy_cycles", 64'(bn), 64'd33);
    check("mul1_result", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    check("mul1_after_fin", {62'd0, busy, done}, 64'd0);

    // -2^31 x -2^31 = 2^62
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, n, bn);
    check("mul2_latency", 64'(n), 64'd33);
    check("mul2_result", {hi_out, lo_out}, 64'h4000_0000_0000_0000);
    tick();

    // -7 / 2 -> q=-3, r=-1
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, n, bn);
    check("div1_latency", 64'(n), 64'd33);
    check("div1_flags", {62'd0, done, div_zero}, 64'd2);
    check("div1_result", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    tick();

    // 0x80000000 / -1 wraps
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n, bn);
    check("div2_result", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    check("div2_no_flag", {63'd0, div_zero}, 64'd0);
    tick();

    // 5 / 0: done+div_zero in C+1, results unchanged
    run_op(1'b0, 1'b1, 32'd5, 32'd0, n, bn);
    check("dz_latency", 64'(n), 64'd1);
    check("dz_flags", {61'd0, busy, done, div_zero}, 64'd7);
    check("dz_hold", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    tick();
    check("dz_after", {61'd0, busy, done, div_zero}, 64'd0);
    check("dz_hold2", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

    // Both starts together, then extra starts during MULT: only 3*5 runs
    mult_start = 1'b1;
    div_start  = 1'b1;
    a_in = 32'd3;
    b_in = 32'd5;
    tick();
    dones  = int'(done);
    cap_hi = '0;
    cap_lo = '0;
    for (int k = 2; k <= 60; k++) begin
      if (k >= 5 && k <= 8) begin
        mult_start = 1'b1;
        div_start  = 1'b1;
        a_in = 32'd9;
        b_in = 32'd9;
      end else begin
        mult_start = 1'b0;
        div_start  = 1'b0;
      end
      tick();
      if (done) begin
        dones++;
        cap_hi = hi_out;
        cap_lo = lo_out;
      end
    end
    check("both_done_count", 64'(dones), 64'd1);
    check("both_result", {cap_hi, cap_lo}, 64'd15);

    // Reset at C+10 aborts a multiply
    run_op(1'b1, 1'b0, 32'd6, 32'd7, n, bn);
    check("pre_abort_result", {hi_out, lo_out}, 64'd42);
    tick();
    mult_start = 1'b1;
    a_in = 32'd7;
    b_in = 32'hFFFF_FFFD;
    tick();
    mult_start = 1'b0;
    repeat (9) tick();
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_outputs", {hi_out, lo_out}, 64'd0);
    check("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // Back-to-back: new start in the cycle after FIN
    run_op(1'b1, 1'b0, 32'hFFFF_FFFA, 32'd7, n, bn);
    check("b2b_first", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFD6);
    tick();
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, n, bn);
    check("b2b_latency", 64'(n), 64'd33);
    check("b2b_second", {hi_out, lo_out}, 64'h0000_0002_FFFF_FFF2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
